// File: rtl/char_buf_pkg.sv
// Shared geometry, cell layout and clear-sweep state encoding for the VGA text buffer.
package char_buf_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] CLEAR_WORD = 32'hFFF0_0020;

  localparam int FG_HI = 31;
  localparam int FG_LO = 20;
  localparam int BG_HI = 19;
  localparam int BG_LO = 8;
  localparam int CH_HI = 7;
  localparam int CH_LO = 0;

  typedef struct packed {
    logic [11:0] fg;
    logic [11:0] bg;
    logic [7:0]  ch;
  } cell_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } clr_state_e;

  // Column occupies the high bits so one screen column is a contiguous run of rows.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] col, input logic [4:0] row);
    return {col, row};
  endfunction

endpackage

// File: rtl/char_ram.sv
// Simple dual-port cell store: one write port, two registered read-first read ports.
module char_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the output registers reset; the array itself is cleared by the sweep.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= mem_q[raddr_a_i];
      rdata_b_q <= mem_q[raddr_b_i];
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/vga_char_buf.sv
// Text-mode cell buffer: CPU read/write port, renderer read port, and a post-reset clear sweep.
module vga_char_buf #(
  parameter int ADDR_W = char_buf_pkg::ADDR_W,
  parameter int DATA_W = char_buf_pkg::DATA_W,
  parameter logic [DATA_W-1:0] CLEAR_WORD = char_buf_pkg::CLEAR_WORD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rdaddr,
  input  logic [ADDR_W-1:0] wraddr,
  input  logic [DATA_W-1:0] datain,
  input  logic              we,
  output logic [DATA_W-1:0] dataout,
  output logic [DATA_W-1:0] data_read,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  char_buf_pkg::clr_state_e state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= char_buf_pkg::ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ram_we    = 1'b0;
    ram_waddr = wraddr;
    ram_wdata = datain;
    busy      = reset || (state_q == char_buf_pkg::ST_CLEAR);
    case (state_q)
      char_buf_pkg::ST_CLEAR: begin
        ram_we    = !reset;
        ram_waddr = clr_cnt_q;
        ram_wdata = CLEAR_WORD;
        // Terminal address ends the sweep explicitly rather than relying on wrap.
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = char_buf_pkg::ST_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      char_buf_pkg::ST_RUN: begin
        ram_we = we && !reset;
      end
      default: state_d = char_buf_pkg::ST_CLEAR;
    endcase
  end

  char_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk_i    (clock),
    .rst_i    (reset),
    .we_i     (ram_we),
    .waddr_i  (ram_waddr),
    .wdata_i  (ram_wdata),
    .raddr_a_i(rdaddr),
    .raddr_b_i(wraddr),
    .rdata_a_o(dataout),
    .rdata_b_o(data_read)
  );

endmodule

// File: tb/tb_vga_char_buf.sv
// Directed bench for vga_char_buf: sweep timing, dropped busy writes, read-first behaviour, corners.
module tb_vga_char_buf;

  localparam logic [31:0] CW = 32'hFFF0_0020;

  logic        clock;
  logic        reset;
  logic [11:0] rdaddr;
  logic [11:0] wraddr;
  logic [31:0] datain;
  logic        we;
  logic [31:0] dataout;
  logic [31:0] data_read;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int edges;
  int bad;

  vga_char_buf dut (
    .clock    (clock),
    .reset    (reset),
    .rdaddr   (rdaddr),
    .wraddr   (wraddr),
    .datain   (datain),
    .we       (we),
    .dataout  (dataout),
    .data_read(data_read),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_sweep(inout int n);
    while (busy === 1'b1 && n < 6000) begin
      step();
      n++;
    end
  endtask

  initial begin
    reset  = 1'b1;
    rdaddr = '0;
    wraddr = '0;
    datain = '0;
    we     = 1'b0;
    repeat (3) step();
    check("reset_dataout", dataout, 32'h0);
    check("reset_data_read", data_read, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h1);

    // Release; after two sweep edges the clear counter sits at 2.
    reset = 1'b0;
    edges = 0;
    step(); edges++;
    step(); edges++;
    we = 1'b1; wraddr = 12'd5; datain = 32'hDEAD_BEEF;
    step(); edges++;
    wraddr = 12'd2; datain = 32'hCAFE_F00D;
    step(); edges++;
    we = 1'b0;
    wait_sweep(edges);
    check("sweep_length", edges, 4096);

    bad = 0;
    for (int a = 0; a < 4096; a++) begin
      rdaddr = a[11:0];
      step();
      if (dataout !== CW) bad++;
    end
    check("sweep_all_cells_bad", bad, 0);

    wraddr = 12'd5; step();
    check("busy_write_addr5", data_read, CW);
    wraddr = 12'd2; step();
    check("busy_write_addr2", data_read, CW);

    check("cell_addr_0a3", {20'h0, char_buf_pkg::cell_addr(7'd5, 5'd3)}, 32'h0A3);
    check("cell_addr_01f", {20'h0, char_buf_pkg::cell_addr(7'd0, 5'd31)}, 32'h01F);

    // CPU write and readback on both ports.
    wraddr = 12'h0A3; datain = 32'h0F00_0041; we = 1'b1;
    step();
    we = 1'b0;
    check("cpu_rd_old", data_read, CW);
    step();
    check("cpu_rd_new", data_read, 32'h0F00_0041);
    rdaddr = 12'h0A3; step();
    check("render_0a3", dataout, 32'h0F00_0041);

    // Read-during-write on the renderer port returns old contents.
    wraddr = 12'd7; datain = 32'h1234_5678; we = 1'b1; rdaddr = 12'd7;
    step();
    we = 1'b0;
    check("rdw_old", dataout, CW);
    step();
    check("rdw_new", dataout, 32'h1234_5678);

    // Corner addresses.
    we = 1'b1;
    wraddr = 12'h000; datain = 32'h1111_0001; step();
    wraddr = 12'hFFF; datain = 32'h2222_0002; step();
    wraddr = 12'h01F; datain = 32'h3333_0003; step();
    we = 1'b0;
    wraddr = 12'h000; rdaddr = 12'hFFF; step();
    check("corner_000_cpu", data_read, 32'h1111_0001);
    check("corner_fff_rend", dataout, 32'h2222_0002);
    wraddr = 12'hFFF; rdaddr = 12'h01F; step();
    check("corner_fff_cpu", data_read, 32'h2222_0002);
    check("corner_01f_rend", dataout, 32'h3333_0003);
    wraddr = 12'h01F; rdaddr = 12'h000; step();
    check("corner_01f_cpu", data_read, 32'h3333_0003);
    check("corner_000_rend", dataout, 32'h1111_0001);

    // Restart the sweep, then interrupt it at count 1000.
    reset = 1'b1; step();
    reset = 1'b0;
    edges = 0;
    repeat (1000) begin step(); edges++; end
    check("mid_busy_before", {31'h0, busy}, 32'h1);
    reset = 1'b1; wraddr = 12'h000; rdaddr = 12'hFFF;
    step();
    check("mid_reset_dataout", dataout, 32'h0);
    check("mid_reset_data_read", data_read, 32'h0);
    check("mid_reset_busy", {31'h0, busy}, 32'h1);
    reset = 1'b0;
    edges = 0;
    wait_sweep(edges);
    check("mid_sweep_length", edges, 4096);
    step();
    check("mid_recleared_000", data_read, CW);
    check("mid_recleared_fff", dataout, CW);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
